// File: rtl/fft_input_loader.sv
// fft_input_loader: packs complex samples into 8-sample frames and drains each frame as pairs (x[k], x[k+4]), k = 0..3.
// Define FFT_LOADER_PINGPONG_EN to add a second bank so one frame loads while the previous one drains.
module fft_input_loader #(
  parameter int DATA_W = 25
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2*DATA_W-1:0] in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [2*DATA_W-1:0] pair_a_o,
  output logic [2*DATA_W-1:0] pair_b_o,
  output logic [1:0]          pair_idx_o,
  output logic                pair_valid_o,
  output logic                frame_start_o
);
  localparam int SW = 2 * DATA_W;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  state_t        r_state;
  logic [1:0]    r_full;
  logic [2:0]    r_wr_idx;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [1:0]    r_k;
  logic [SW-1:0] r_pair_a;
  logic [SW-1:0] r_pair_b;
  logic [1:0]    r_pair_idx;
  logic          r_pair_vld;
  logic          r_frame_start;

  logic          w_wr_fire;
  logic          w_launch;
  logic          w_other_full;

`ifdef FFT_LOADER_PINGPONG_EN
  localparam bit PP = 1'b1;
  logic [SW-1:0] r_mem [16];
  logic [3:0]    w_wr_addr;
  logic [3:0]    w_rd_a_addr;
  logic [3:0]    w_rd_b_addr;
  assign w_wr_addr   = {r_wr_bank, r_wr_idx};
  assign w_rd_a_addr = {r_rd_bank, 1'b0, r_k};
  assign w_rd_b_addr = {r_rd_bank, 1'b1, r_k};
`else
  localparam bit PP = 1'b0;
  logic [SW-1:0] r_mem [8];
  logic [2:0]    w_wr_addr;
  logic [2:0]    w_rd_a_addr;
  logic [2:0]    w_rd_b_addr;
  assign w_wr_addr   = r_wr_idx;
  assign w_rd_a_addr = {1'b0, r_k};
  assign w_rd_b_addr = {1'b1, r_k};
`endif

  assign in_ready_o   = !r_full[r_wr_bank];
  assign w_wr_fire    = in_valid_i && in_ready_o;
  // r_k is 0 whenever IDLE, so the first pair launches on the same edge that spots a full bank
  assign w_launch     = (r_state == ST_DRAIN) || r_full[r_rd_bank];
  assign w_other_full = PP && r_full[~r_rd_bank];

  always_ff @(posedge clk_i) begin
    if (rst_i && w_wr_fire) begin
      r_mem[w_wr_addr] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= ST_IDLE;
      r_full        <= '0;
      r_wr_idx      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_k           <= '0;
      r_pair_a      <= '0;
      r_pair_b      <= '0;
      r_pair_idx    <= '0;
      r_pair_vld    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        r_wr_idx <= r_wr_idx + 3'd1;
        if (r_wr_idx == 3'd7) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= r_wr_bank ^ PP;
        end
      end

      r_pair_vld    <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_launch) begin
        r_pair_a      <= r_mem[w_rd_a_addr];
        r_pair_b      <= r_mem[w_rd_b_addr];
        r_pair_idx    <= r_k;
        r_pair_vld    <= 1'b1;
        r_frame_start <= (r_k == 2'd0);
        r_k           <= r_k + 2'd1;
        if (r_k == 2'd3) begin
          // Different bank from any write-side set this edge, so both updates stick
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= r_rd_bank ^ PP;
          r_state           <= w_other_full ? ST_DRAIN : ST_IDLE;
        end else begin
          r_state <= ST_DRAIN;
        end
      end
    end
  end

  assign pair_a_o      = r_pair_a;
  assign pair_b_o      = r_pair_b;
  assign pair_idx_o    = r_pair_idx;
  assign pair_valid_o  = r_pair_vld;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: random and patterned frames scored against a frame-level model.
module tb_fft_input_loader;
  localparam int DATA_W = 25;
  localparam int SW     = 2 * DATA_W;
`ifdef FFT_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk_i;
  logic          rst_i;
  logic [SW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [SW-1:0] pair_a_o;
  logic [SW-1:0] pair_b_o;
  logic [1:0]    pair_idx_o;
  logic          pair_valid_o;
  logic          frame_start_o;

  fft_input_loader #(.DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .pair_a_o     (pair_a_o),
    .pair_b_o     (pair_b_o),
    .pair_idx_o   (pair_idx_o),
    .pair_valid_o (pair_valid_o),
    .frame_start_o(frame_start_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic [1:0]    idx;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [SW-1:0] fb[$];
  int            occ[$];
  int            cyc    = 0;
  int            last_c = 0;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
  endtask

  function automatic logic [SW-1:0] rnd();
    return SW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [SW-1:0] mk(input int n);
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
    re = DATA_W'(n);
    im = -re;
    return {re, im};
  endfunction

  // A full frame of 8 yields pairs (x[k], x[k+4]) on the 4 edges after the edge taking x[7];
  // the frame holds its bank for edges t..t+3
  function automatic void model_accept(input logic [SW-1:0] d, input int t);
    fb.push_back(d);
    if (fb.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.a   = fb[k];
        e.b   = fb[k+4];
        e.idx = 2'(k);
        e.cyc = t + 1 + k;
        sb.push_back(e);
      end
      occ.push_back(t);
      last_c = t;
      fb.delete();
    end
  endfunction

  function automatic void model_reset();
    sb.delete();
    fb.delete();
    occ.delete();
  endfunction

  function automatic int occupied(input int t);
    int n;
    n = 0;
    foreach (occ[i]) if (occ[i] <= t && t < occ[i] + 4) n++;
    return n;
  endfunction

  task automatic drive(input logic v, input logic [SW-1:0] d, output logic acc);
    @(negedge clk_i);
    rst_i      = 1'b1;
    in_valid_i = v;
    in_data_i  = d;
    acc        = v && in_ready_o;
    if (acc) model_accept(d, cyc + 1);
  endtask

  task automatic send(input logic [SW-1:0] d);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      drive(1'b1, d, acc);
      tries++;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: sample %0h not accepted, got %0d tries, expected acceptance", d, tries);
    end
  endtask

  task automatic do_reset(input int n);
    rst_i      = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = rnd();
    model_reset();
    for (int i = 1; i < n; i++) begin
      @(negedge clk_i);
      in_data_i = rnd();
    end
    @(negedge clk_i);
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    logic rst_edge;
    exp_t e;
    forever begin
      @(posedge clk_i);
      cyc++;
      rst_edge = !rst_i;
      #1;
      if (rst_edge) begin
        chk("rst_pair_valid", 64'(pair_valid_o), 64'd0);
        chk("rst_frame_start", 64'(frame_start_o), 64'd0);
        chk("rst_pair_a", 64'(pair_a_o), 64'd0);
        chk("rst_pair_b", 64'(pair_b_o), 64'd0);
        chk("rst_pair_idx", 64'(pair_idx_o), 64'd0);
      end else begin
        chk("in_ready", 64'(in_ready_o), 64'(occupied(cyc) < NB));
        if (pair_valid_o) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pair @cycle %0d: got idx %0d, expected no pair", cyc, pair_idx_o);
          end else begin
            e = sb.pop_front();
            chk("pair_cycle", 64'(cyc), 64'(e.cyc));
            chk("pair_a", 64'(pair_a_o), 64'(e.a));
            chk("pair_b", 64'(pair_b_o), 64'(e.b));
            chk("pair_idx", 64'(pair_idx_o), 64'(e.idx));
            chk("frame_start", 64'(frame_start_o), 64'(e.idx == 2'd0));
          end
        end else begin
          chk("frame_start_idle", 64'(frame_start_o), 64'd0);
          if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            $display("FAIL missing_pair @cycle %0d: got no pair, expected idx %0d due at cycle %0d", cyc, e.idx, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    int   guard;
    rst_i      = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = rnd();
    do_reset(2);

    // Single frame re = n, im = -n
    for (int n = 0; n < 8; n++) send(mk(n));
    repeat (8) drive(1'b0, rnd(), acc);

    // Three frames with valid held high
    for (int i = 0; i < 24; i++) send(rnd());
    repeat (8) drive(1'b0, rnd(), acc);

    // Gapped input, same values as the dense frame
    for (int n = 0; n < 8; n++) begin
      send(mk(n));
      drive(1'b0, rnd(), acc);
    end
    repeat (8) drive(1'b0, rnd(), acc);

    // Random valid pattern
    for (int i = 0; i < 16; i++) begin
      send(rnd());
      repeat ($urandom_range(2)) drive(1'b0, rnd(), acc);
    end
    repeat (8) drive(1'b0, rnd(), acc);

    // Reset while pair k = 2 is on the outputs, then a fresh frame
    for (int i = 0; i < 8; i++) send(rnd());
    guard = 0;
    while (cyc < last_c + 3 && guard < 50) begin
      drive(1'b0, rnd(), acc);
      guard++;
    end
    do_reset(1);
    for (int n = 0; n < 8; n++) send(mk(n + 100));

    guard = 0;
    while (sb.size() > 0 && guard < 30) begin
      drive(1'b0, rnd(), acc);
      guard++;
    end
    repeat (4) drive(1'b0, rnd(), acc);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Upstream feeder of the radix-2 DIF stage-1 butterfly in the 8-point FFT datapath. Accepts a stream of packed complex samples through a valid/ready handshake, assembles them into 8-sample frames, and drains each frame as four consecutive pairs (x[k], x[k+4]), k = 0..3. These pairs are exactly the a/b operands the stage-1 butterfly consumes on its counter slots 0..3. An optional ping-pong bank lets one frame load while the previous one drains.

## Interface
- DATA_W, 25: width of each real/imag component; packed sample = {re[2*DATA_W-1:DATA_W], im[DATA_W-1:0]}, both two's complement.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- in_data_i  in  2*DATA_W  packed complex input sample.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  loader can accept; transfer occurs when in_valid_i && in_ready_o at a rising edge.
- pair_a_o  out  2*DATA_W  x[k] of the draining frame (butterfly signal_a_i).
- pair_b_o  out  2*DATA_W  x[k+4] of the draining frame (butterfly signal_b_i).
- pair_idx_o  out  2  k of the current pair.
- pair_valid_o  out  1  pair_a_o/pair_b_o/pair_idx_o are valid; push-only, no backpressure.
- frame_start_o  out  1  one-cycle pulse coincident with pair k = 0.

## Operation
- Storage: bank(s) of 8 entries × 2*DATA_W; per-bank full flag; write pointer wr_idx (3 bit), wr_bank, rd_bank.
- Write side: each accepted sample stored at bank[wr_bank][wr_idx]; wr_idx increments, wraps 7→0. On accepting index 7, full[wr_bank] ← 1 and wr_bank toggles (ping-pong build only).
- in_ready_o = !full[wr_bank], from registered flags only (no combinational path from in_valid_i).
- Read FSM states: IDLE, DRAIN.
  - IDLE → DRAIN when full[rd_bank] = 1; k ← 0.
  - DRAIN: each cycle registers pair_a_o = bank[rd_bank][k], pair_b_o = bank[rd_bank][k+4], pair_idx_o = k, pair_valid_o = 1, frame_start_o = (k == 0); k increments.
  - On the edge launching k = 3: full[rd_bank] ← 0, rd_bank toggles (ping-pong build); next state DRAIN if the other bank is already full (back-to-back, no bubble), else IDLE.
- Simultaneous set/clear of different banks on one edge are both honoured; a bank freed on edge E accepts writes from the cycle after E.
- Data passes unmodified; no arithmetic or width change.
- Reset (rst_i = 0 at edge): wr_idx, wr_bank, rd_bank, k ← 0; all full flags ← 0; FSM ← IDLE; partial frame discarded. Output reset values: pair_valid_o 0, frame_start_o 0, pair_idx_o 0, pair_a_o 0, pair_b_o 0, in_ready_o 1 from the first cycle after reset. Memory contents are not reset.
- Outside DRAIN, pair_a_o/pair_b_o/pair_idx_o hold their last values; pair_valid_o = 0.

## Timing
- Sample 7 accepted at edge E0 → pair k = 0 visible after E1; k = 1,2,3 after E2, E3, E4; pair_valid_o high for exactly 4 cycles per frame.
- Bank freed at E4.
- Ping-pong: continuous 1 sample/cycle input never stalls (8-cycle fill > 4-cycle drain).
- Single-bank: in_ready_o low from after E0 until after E4 (4 stall cycles per frame).

## Configuration
- FFT_LOADER_PINGPONG_EN defined: two banks, wr_bank/rd_bank toggle as above.
- Not defined: one bank, wr_bank/rd_bank fixed at 0; writes blocked while the frame is full/draining; all other behaviour identical.

## Test plan
- Reset: hold rst_i = 0 two cycles with in_valid_i = 1 → pair_valid_o = 0, frame_start_o = 0, pair outputs 0, no sample captured; in_ready_o = 1 after release.
- Single frame: samples re = n, im = -n, n = 0..7, one per cycle → 4 pairs, pair k: a = {k, -k}, b = {k+4, -(k+4)}, idx = k, frame_start_o only at k = 0, starting one cycle after sample 7 accepted.
- Continuous 3 frames (ping-pong build), in_valid_i held 1 → in_ready_o never drops; 12 pairs with correct frame order and values.
- Same stimulus, single-bank build → in_ready_o low exactly 4 cycles after each frame's sample 7; all 12 pairs correct.
- Gapped input: in_valid_i toggling 1/0 → samples stored only on handshake; pair values unchanged versus the dense case.
- Reset mid-drain at k = 2, then fresh frame → no further pairs from the old frame; new frame drains as k = 0..3 with correct data.
